plot_arbiter: RTL
=================

# plot_arbiter

Shares the single VGA adapter plot port between N pixel requesters (ball, brick, platform, loader draw engines). A round-robin arbiter grants one requester at a time for a burst of pixels, with a bounded burst length for fairness. The winning pixel is registered onto the plot port with optional forced-black erase. It replaces the state-driven combinational draw multiplexer between the draw engines and `vga_adapter`.

## Interface
- `N_REQ`, 4, number of requesters; index 0 wins ties after reset
- `MAX_BURST`, 32, maximum pixels transferred per grant before forced rotation (≥1)
- `COORD_W`, 10, x/y coordinate width
- `clk` input 1 system clock (50 MHz)
- `resetn` input 1 reset, synchronous, active-low
- `req` input N_REQ per-requester pixel valid; held with pixel data until granted
- `last` input N_REQ marks the final pixel of the requester's sprite burst
- `x_in` input N_REQ*COORD_W packed x, requester i at bits [i*COORD_W +: COORD_W]
- `y_in` input N_REQ*COORD_W packed y, same packing
- `colour_in` input N_REQ*3 packed RGB colour
- `erase` input 1 when high on a transfer, plotted colour is forced to 3'b000
- `gnt` output N_REQ one-hot accept; the pixel of requester i transfers on any rising edge with `req[i] & gnt[i]`
- `plot_x`, `plot_y` output COORD_W registered coordinate to `vga_adapter`
- `plot_colour` output 3 registered colour
- `plot` output 1 registered write strobe
- `busy` output 1 high while in S_BURST
- `owner` output clog2(N_REQ) index of the current/last grant holder

## Operation
- FSM states: S_IDLE, S_BURST.
- S_IDLE: `gnt`=0. If `|req`, choose `sel` as the first set `req` bit searching from `ptr` upward with wrap. Load `owner`←`sel`, clear `burst_cnt`, go to S_BURST. Otherwise stay in S_IDLE.
- S_BURST: `gnt[owner]` = `req[owner]`; all other `gnt` bits are 0. `gnt` is combinational from registered state and `req` only.
- On each transfer: `burst_cnt`++; capture the pixel into the output registers.
- Exit S_BURST to S_IDLE, with `ptr`←`owner`+1 (mod N_REQ), when any of these hold:
  - a transfer occurs with `last[owner]`=1;
  - a transfer makes `burst_cnt`==MAX_BURST (preemption);
  - `req[owner]`=0 (abandon; no transfer).
- Output registers update every cycle: `plot`←transfer.
  - On a transfer: `plot_x`/`plot_y`←the owner's coordinate; `plot_colour`←`erase` ? 3'b000 : the owner's colour.
  - Without a transfer: coordinate/colour hold their previous value.
- `burst_cnt` width is clog2(MAX_BURST+1) and never wraps; it saturates at the exit condition.

## Timing
- Reset values: `gnt`=0, `plot`=0, `plot_x`=`plot_y`=0, `plot_colour`=0, `busy`=0, `owner`=0, `ptr`=0, state S_IDLE.
- Arbitration latency: 1 cycle from `req` rising (in S_IDLE) to `gnt`.
- Within a burst, transfers run back-to-back at 1 pixel/cycle.
- Plot latency: the transfer edge sets `plot`=1 for exactly the following cycle.
- Rotation gap: 1 idle cycle (S_IDLE) between bursts, including when the same requester is re-granted after preemption.
- Simultaneous requests after reset: grant order 0,1,2,3,0…
- A requester that drops `req` mid-burst loses the grant immediately; no pixel is plotted that cycle.
- `erase` is sampled only on transfer edges.
- Reset mid-burst: all outputs return to reset values on the next edge; no partial pixel is emitted.
- MAX_BURST=1: every transfer exits to S_IDLE, giving strict per-pixel round-robin.

## Structure
- Shared package `draw_pkg`:
  - `COORD_W`
  - colour constant `BLACK`=3'b000
  - `plot_arb_state_t` enum (S_IDLE, S_BURST)
- Sub-module `rr_pick`: combinational round-robin priority encoder. Inputs `req`, `ptr`; outputs `sel` and `any`.
- The arbiter proper holds the FSM, `burst_cnt`, `ptr`, the output registers and the unpacking muxes.

## Test plan
- Single requester 2, `req` held 4 cycles with `last` on pixel 4 at (10,20..23), colour 3'b101 -> `gnt[2]` starts 1 cycle after `req`; `plot` pulses for 4 consecutive cycles with y=20..23; back to S_IDLE; `ptr`=3.
- All four `req` high continuously, `last` on every pixel -> owners 0,1,2,3,0 with a 1-cycle gap between each; exactly one `gnt` bit high at a time.
- MAX_BURST=32, requester 1 streams 40 pixels, requester 3 also requesting -> 32 pixels from 1, then 3's burst, then the remaining 8 from 1.
- `erase`=1 on the second transfer of a 3-pixel burst with colour 3'b111 -> `plot_colour` sequence 111, 000, 111.
- Requester 0 drops `req` after 2 transfers without `last` -> `gnt` goes to 0 in the same cycle, no third `plot`, next requester is granted.
- `resetn` low during burst pixel 5 -> next cycle `plot`=0, `gnt`=0, `busy`=0, `owner`=0; after release, requester 0 wins the tie.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared draw-path definitions: coordinate width, colour constants, arbiter FSM states.
package draw_pkg;

    localparam int COORD_W = 10;

    localparam logic [2:0] BLACK = 3'b000;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } plot_arb_state_t;

endpackage

// File: rtl/plot_arbiter_if.sv
// Plot-port bundle between the draw engines (master) and the arbiter (slave).
interface plot_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int COORD_W = draw_pkg::COORD_W
);
    localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         last;
    logic [N_REQ*COORD_W-1:0] x_in;
    logic [N_REQ*COORD_W-1:0] y_in;
    logic [N_REQ*3-1:0]       colour_in;
    logic                     erase;
    logic [N_REQ-1:0]         gnt;
    logic [COORD_W-1:0]       plot_x;
    logic [COORD_W-1:0]       plot_y;
    logic [2:0]               plot_colour;
    logic                     plot;
    logic                     busy;
    logic [OWN_W-1:0]         owner;

    modport master (
        output req, last, x_in, y_in, colour_in, erase,
        input  gnt, plot_x, plot_y, plot_colour, plot, busy, owner
    );

    modport slave (
        input  req, last, x_in, y_in, colour_in, erase,
        output gnt, plot_x, plot_y, plot_colour, plot, busy, owner
    );

endinterface

// File: rtl/plot_arbiter_rr_pick.sv
// Round-robin priority encoder: first set req bit at or above ptr, wrapping.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    sel,
    output logic             any
);

    // Scan from the farthest offset down so the nearest requester overwrites sel last.
    always_comb begin
        sel = '0;
        any = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N_REQ]) begin
                sel = PW'((int'(ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin burst arbiter sharing the single vga_adapter plot port among the draw engines.
// N_REQ/COORD_W must match the parameters of the connected plot_arbiter_if.
module plot_arbiter
    import draw_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 32,
    parameter int COORD_W   = draw_pkg::COORD_W
) (
    input  logic          clk,
    input  logic          resetn,
    plot_arbiter_if.slave bus
);

    localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    plot_arb_state_t    state_q, state_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [OWN_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               plot_q, plot_d;
    logic [COORD_W-1:0] plot_x_q, plot_x_d;
    logic [COORD_W-1:0] plot_y_q, plot_y_d;
    logic [2:0]         plot_colour_q, plot_colour_d;

    logic [OWN_W-1:0]   sel;
    logic               any;
    logic               own_req;
    logic               own_last;
    logic               xfer;
    logic [CNT_W-1:0]   cnt_inc;
    logic [OWN_W-1:0]   owner_nxt;
    logic [N_REQ-1:0]   gnt;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .sel (sel),
        .any (any)
    );

    // Owner-side decode; gnt depends only on registered state and live req.
    always_comb begin
        own_req   = bus.req[owner_q];
        own_last  = bus.last[owner_q];
        xfer      = (state_q == S_BURST) && own_req;
        cnt_inc   = burst_cnt_q + CNT_W'(1);
        owner_nxt = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + OWN_W'(1);
        gnt       = '0;
        if (state_q == S_BURST) begin
            gnt[owner_q] = own_req;
        end
    end

    // Next-state: pick a winner in idle; leave the burst on last, preemption or abandon.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (any) begin
                    owner_d     = sel;
                    burst_cnt_d = '0;
                    state_d     = S_BURST;
                end
            end
            S_BURST: begin
                if (!own_req) begin
                    state_d = S_IDLE;
                    ptr_d   = owner_nxt;
                end else begin
                    burst_cnt_d = cnt_inc;
                    if (own_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
                        state_d = S_IDLE;
                        ptr_d   = owner_nxt;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Plot-port capture: strobe follows the transfer, pixel data holds between transfers.
    always_comb begin
        plot_d        = xfer;
        plot_x_d      = plot_x_q;
        plot_y_d      = plot_y_q;
        plot_colour_d = plot_colour_q;
        if (xfer) begin
            plot_x_d      = bus.x_in[int'(owner_q) * COORD_W +: COORD_W];
            plot_y_d      = bus.y_in[int'(owner_q) * COORD_W +: COORD_W];
            plot_colour_d = bus.erase ? BLACK : bus.colour_in[int'(owner_q) * 3 +: 3];
        end
    end

    // State and output registers; synchronous reset drops any in-flight pixel.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            owner_q       <= '0;
            ptr_q         <= '0;
            burst_cnt_q   <= '0;
            plot_q        <= 1'b0;
            plot_x_q      <= '0;
            plot_y_q      <= '0;
            plot_colour_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            burst_cnt_q   <= burst_cnt_d;
            plot_q        <= plot_d;
            plot_x_q      <= plot_x_d;
            plot_y_q      <= plot_y_d;
            plot_colour_q <= plot_colour_d;
        end
    end

    assign bus.gnt         = gnt;
    assign bus.plot        = plot_q;
    assign bus.plot_x      = plot_x_q;
    assign bus.plot_y      = plot_y_q;
    assign bus.plot_colour = plot_colour_q;
    assign bus.busy        = (state_q == S_BURST);
    assign bus.owner       = owner_q;

endmodule
